// File: rtl/t48_bus_cycle_sched.sv
// External-bus cycle scheduler for the T48 timing generator: arbitrates fetch,
// MOVX read/write and expander PROG, and drives the generator's strobe requests.
module t48_bus_cycle_sched #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic       clk_i,
  input  logic       res_i,
  input  logic       en_clk_i,
  input  logic [2:0] mstate_i,
  input  logic       second_cycle_i,
  input  logic       fetch_req_i,
  input  logic       rd_req_i,
  input  logic       wr_req_i,
  input  logic       exp_req_i,
  output logic [3:0] ack_o,
  output logic [1:0] grant_o,
  output logic       busy_o,
  output logic       multi_cycle_o,
  output logic       assert_psen_o,
  output logic       assert_prog_o,
  output logic       assert_rd_o,
  output logic       assert_wr_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_MC1   = 2'd2;
  localparam logic [1:0] ST_MC2   = 2'd3;

  localparam logic [2:0] MS_S1 = 3'd0;
  localparam logic [2:0] MS_S2 = 3'd1;
  localparam logic [2:0] MS_S4 = 3'd3;
  localparam logic [2:0] MS_S5 = 3'd4;

  localparam logic [1:0] G_FETCH = 2'd0;
  localparam logic [1:0] G_RD    = 2'd1;
  localparam logic [1:0] G_WR    = 2'd2;
  localparam logic [1:0] G_EXP   = 2'd3;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic [1:0] grant;
  logic [3:0] starve_cnt;
  logic       multi_cycle;
  logic [3:0] ack;

  logic       decide;
  logic       any_req;
  logic [1:0] winner;

  always_comb begin
    decide  = en_clk_i && (mstate_i == MS_S1) && (state == ST_IDLE);
    any_req = fetch_req_i | rd_req_i | wr_req_i | exp_req_i;
    // A fetch that has lost LIMIT arbitrations in a row jumps the fixed priority.
    if (fetch_req_i && (starve_cnt == LIMIT)) winner = G_FETCH;
    else if (exp_req_i)                        winner = G_EXP;
    else if (wr_req_i)                         winner = G_WR;
    else if (rd_req_i)                         winner = G_RD;
    else                                       winner = G_FETCH;
  end

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state       <= ST_IDLE;
      grant       <= G_FETCH;
      starve_cnt  <= '0;
      multi_cycle <= 1'b0;
      ack         <= '0;
    end else begin
      ack <= '0;
      if (en_clk_i) begin
        if (mstate_i == MS_S2) multi_cycle <= 1'b0;
        if (decide) begin
          if (!fetch_req_i || winner == G_FETCH) starve_cnt <= '0;
          else if (starve_cnt != LIMIT)          starve_cnt <= starve_cnt + 4'd1;
        end
        case (state)
          ST_IDLE: begin
            if (decide && any_req) begin
              grant       <= winner;
              state       <= (winner == G_FETCH) ? ST_FETCH : ST_MC1;
              multi_cycle <= (winner != G_FETCH);
            end
          end
          ST_FETCH: begin
            if (mstate_i == MS_S5) begin
              state <= ST_IDLE;
              ack   <= 4'b0001;
            end
          end
          ST_MC1: begin
            if (mstate_i == MS_S5 && !second_cycle_i) state <= ST_MC2;
          end
          ST_MC2: begin
            // A missing second cycle is a protocol fault: drop the operation without ack.
            if (mstate_i == MS_S5) begin
              state <= ST_IDLE;
              if (second_cycle_i) ack <= 4'b0001 << grant;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    assert_psen_o = (state == ST_FETCH) && (mstate_i == MS_S4);
    assert_prog_o = (state == ST_MC1) && (grant == G_EXP) && (mstate_i == MS_S4) && !second_cycle_i;
    assert_rd_o   = (state == ST_MC1) && (grant == G_RD)  && (mstate_i == MS_S5) && !second_cycle_i;
    assert_wr_o   = (state == ST_MC1) && (grant == G_WR)  && (mstate_i == MS_S5) && !second_cycle_i;
  end

  assign ack_o         = ack;
  assign grant_o       = grant;
  assign busy_o        = (state != ST_IDLE);
  assign multi_cycle_o = multi_cycle;

endmodule
